alu_exec_unit: RTL
==================

# alu_exec_unit

Multi-cycle execution unit that consumes the 4-bit ALU control codes produced by the datapath's ALU control decoder and computes the result over a valid/ready handshake. Logic, add/sub and compare ops complete in one cycle; shifts run through an iterative one-bit-per-cycle shifter unless the barrel-shift option is compiled in. It sits between decode/operand-read and writeback in the multi-cycle core variant, where a single-cycle 32-bit barrel shifter is too costly.

## Interface
- XLEN, 32, operand/result width; shift amount is b[4:0] (fixed 5 bits, XLEN must be 32)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  unit can accept; high only in IDLE
- aluControl  in  4  op code (see Operation)
- a  in  XLEN  operand A (shift source)
- b  in  XLEN  operand B (shift amount b[4:0])
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)
- illegal  out  1  registered; code not in table

## Operation
- Codes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 xor, 0011 sll, 1000 srl, 1010 sra, 0100 slt (signed), 0101 sltu. All other codes: illegal=1, result=0, zero=1.
- Add/sub wrap modulo 2^XLEN, no carry/overflow outputs. slt/sltu yield 0 or 1 zero-extended.
- FSM states IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Accept when in_valid&in_ready. Non-shift or shamt=0: compute, register result/zero/illegal, go DONE. Shift with shamt=k>0: latch a into shift register, count=k, latch op, go SHIFT.
- SHIFT: each cycle shift by 1 (sll: zero fill LSB; srl: zero fill MSB; sra: replicate bit XLEN-1), count--; on count reaching 0 register result/zero, go DONE. Inputs ignored; in_ready=0.
- DONE: out_valid=1, outputs stable. On out_ready go IDLE. No same-cycle accept of a new request in DONE.
- Operands and code are sampled only at the accepting edge; later input changes have no effect.

## Timing
- Reset values: state IDLE, in_ready=1 after reset deasserts (0 while reset high), out_valid=0, result=0, zero=0, illegal=0, count=0.
- Reset has priority over all transitions; reset mid-SHIFT or in DONE discards the operation, no out_valid pulse.
- Latency (accept edge to first cycle out_valid=1): 1 cycle for non-shift, shamt=0, illegal; 1+k cycles... precisely: k cycles in SHIFT then DONE, i.e. out_valid high k+1 cycles after accept edge; max 32.
- Throughput: one op per (latency + 1) cycles minimum, DONE->IDLE costs one cycle.
- result/zero/illegal change only on entry to DONE or reset; hold while out_valid=1 and out_ready=0.

## Configuration
- ALU_FAST_SHIFT_EN defined: shifts computed by combinational barrel shifter at accept, go directly to DONE (latency 1 for all ops); SHIFT state and counter not synthesized.
- Undefined: iterative shifter as above.

## Test plan
- Reset held 2 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=0; after release in_ready=1.
- add a=0xFFFFFFFF b=1 -> out_valid 1 cycle after accept, result=0x00000000, zero=1; sub a=5 b=7 -> 0xFFFFFFFE.
- slt a=0x80000000 b=1 -> result=1; sltu same operands -> result=0.
- sra a=0x80000000 b=31 -> result=0xFFFFFFFF, out_valid 32 cycles after accept (1 with ALU_FAST_SHIFT_EN); srl same -> 0x00000001; sll a=1 b=0x20 (shamt 0) -> 1, latency 1.
- Code 1111 -> illegal=1, result=0, zero=1; out_ready held low 5 cycles -> outputs stable, in_ready=0; next op accepted cycle after out_ready.
- Reset asserted mid-SHIFT (sll shamt=20, after 5 cycles) -> IDLE next cycle, no out_valid; subsequent add completes normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready handshake and iterative shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      aluControl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SLT  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1010
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            is_shift;
    logic            start_shift;
    logic [4:0]      shamt;

    assign shamt     = b[4:0];
    assign in_ready  = (state == S_IDLE) && !reset;
    assign out_valid = (state == S_DONE);

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (aluControl)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL: begin
                is_shift = 1'b1;
`ifdef ALU_FAST_SHIFT_EN
                alu_res  = a << shamt;
`else
                alu_res  = a;
`endif
            end
            OP_SRL: begin
                is_shift = 1'b1;
`ifdef ALU_FAST_SHIFT_EN
                alu_res  = a >> shamt;
`else
                alu_res  = a;
`endif
            end
            OP_SRA: begin
                is_shift = 1'b1;
`ifdef ALU_FAST_SHIFT_EN
                alu_res  = $unsigned($signed(a) >>> shamt);
`else
                alu_res  = a;
`endif
            end
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign start_shift = 1'b0;
`else
    logic [XLEN-1:0] sh_reg;
    logic [XLEN-1:0] sh_next;
    logic [3:0]      sh_op;
    logic [4:0]      count;

    // Non-zero shift amounts defer to the iterative path; shamt=0 completes as a plain pass-through.
    assign start_shift = is_shift && (shamt != 5'd0);

    always_comb begin
        sh_next = sh_reg;
        case (sh_op)
            OP_SLL:  sh_next = {sh_reg[XLEN-2:0], 1'b0};
            OP_SRL:  sh_next = {1'b0, sh_reg[XLEN-1:1]};
            default: sh_next = {sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_reg <= '0;
            sh_op  <= '0;
            count  <= '0;
        end else if (state == S_IDLE && in_valid && start_shift) begin
            sh_reg <= a;
            sh_op  <= aluControl;
            count  <= shamt;
        end else if (state == S_SHIFT) begin
            sh_reg <= sh_next;
            count  <= count - 5'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = start_shift ? S_SHIFT : S_DONE;
`ifndef ALU_FAST_SHIFT_EN
            S_SHIFT: if (count == 5'd1) state_next = S_DONE;
`endif
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (state == S_IDLE && in_valid && !start_shift) begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= alu_ill;
        end
`ifndef ALU_FAST_SHIFT_EN
        else if (state == S_SHIFT && count == 5'd1) begin
            result  <= sh_next;
            zero    <= (sh_next == '0);
            illegal <= 1'b0;
        end
`endif
    end

endmodule
